mux4a1_serializer: RTL and testbench
====================================

# mux4a1_serializer

Four-lane to one-lane byte serializer that sits directly upstream of the 8-bit output flip-flop stage of the MUX4a1 path. It samples four 8-bit lanes, each with a valid bit, once every four clkf cycles. It then emits them one per cycle, in lane order 0→3, on a single registered 8-bit bus with valid and frame markers. A free-running 2-bit phase counter provides the slow-domain capture point, so no second clock is needed.

## Interface
- WIDTH, 8, data width per lane and of the output bus

- clkf  input  1  clock; every register updates on the rising edge
- reset  input  1  reset, synchronous, active-low; clock clkf
- in0, in1, in2, in3  input  WIDTH  lane data; sampled only on a capture edge
- valid0, valid1, valid2, valid3  input  1  lane valid; sampled with the matching lane data
- capture_en  output  1  combinational, high when phase==3; tells upstream that lanes are sampled at the coming edge
- data_out  output  WIDTH  registered serialized byte; forced to 0 when its lane was not valid
- valid_out  output  1  registered; the captured valid bit of the lane currently on data_out
- frame_out  output  1  registered; high in the cycle data_out carries lane 0
- phase  output  2  current phase counter value, for debug and for the downstream stage

## Operation
- Phase counter: 0→1→2→3→0, advancing on every clkf edge when reset is high. Wraps unconditionally; there is no stall input.
- Capture: at an edge where phase==3, the block loads all lanes together:
  - hold[i] <= in_i
  - hvalid[i] <= valid_i
  - All four lanes are sampled at the same edge. Inputs on any other edge are ignored.
- Serialize: at an edge where phase==p, the output registers load from lane p of the holding registers:
  - data_out <= hvalid[p] ? hold[p] : 0
  - valid_out <= hvalid[p]
  - frame_out <= (p==0)
- Simultaneous capture and lane-3 output at a phase-3 edge: the output uses the old hold[3]. Nonblocking semantics apply, so the new word is never emitted early.
- Invalid lanes are not skipped. Each slot always takes one cycle, and an invalid lane emits data 0 with valid_out 0.
- Reset (reset==0 at a rising edge):
  - phase, hold[0..3] and hvalid[0..3] clear to 0
  - data_out, valid_out and frame_out clear to 0
  - capture_en therefore reads 0
  - Reset mid-word discards every captured lane not yet emitted. No partial output follows reset release.
- Widths: all data paths are exactly WIDTH bits with no arithmetic. phase is 2 bits and wraps by natural overflow.

## Timing
- Reset values, all outputs: data_out=0, valid_out=0, frame_out=0, phase=0, capture_en=0.
- After reset release, edges 1–3 (phase 0..2) emit zeros with valid_out=0. The first capture happens at edge 4 (phase 3).
- Latency: lanes sampled at capture edge E appear at the output as follows:
  - lane 0 after edge E+1
  - lane 1 after edge E+2
  - lane 2 after edge E+3
  - lane 3 after edge E+4
- frame_out is high for exactly one cycle in every four, aligned with lane 0.
- Throughput: 4 lanes per 4 cycles, with continuous back-to-back words and no bubbles.
- capture_en is combinational from the phase register only. It has no combinational path from any input.

## Test plan
- Reset: hold reset=0 for 3 edges with random inputs. Required: all outputs 0 and phase=0 throughout. After release, phase counts 1,2,3,0 on successive edges.
- Basic word: while capture_en=1, drive in0..in3=0xA1,0xB2,0xC3,0xD4 with all valids=1. Required over the next 4 cycles:
  - data_out = 0xA1,0xB2,0xC3,0xD4
  - valid_out = 1,1,1,1
  - frame_out = 1,0,0,0
- Masked lanes: capture 0x11,0x22,0x33,0x44 with valid=1,0,1,0. Required: data_out = 0x11,0x00,0x33,0x00 and valid_out = 1,0,1,0.
- Back-to-back words: change inputs every capture. Required: a continuous output stream, and the last lane of word N is immediately followed by lane 0 of word N+1 with frame_out=1. Also change inputs at phases 0..2 and confirm these changes have no effect.
- Reset mid-word: capture 0xDE,0xAD,0xBE,0xEF, then assert reset after lane 1 has been emitted. Required:
  - 0xBE and 0xEF are never emitted
  - outputs are 0 on the next edge
  - after release, valid_out stays 0 until 1 cycle after the first new capture
- Width parameter: run the basic-word test with WIDTH=16 and lanes 0x1234,0x5678,0x9ABC,0xDEF0. Required: the same ordering and full 16-bit values.

Source files
------------

// File: rtl/mux4a1_serializer_if.sv
// mux4a1_serializer_if: lane inputs and serialized output bus of the MUX4a1 serializer
//   master: upstream/bench side; drives lanes and valids, observes outputs
//   slave : serializer side; samples lanes, drives capture_en/data_out/valid_out/frame_out/phase
interface mux4a1_serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in0, in1, in2, in3;
    logic             valid0, valid1, valid2, valid3;
    logic             capture_en;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             frame_out;
    logic [1:0]       phase;

    modport master (
        output in0, in1, in2, in3, valid0, valid1, valid2, valid3,
        input  capture_en, data_out, valid_out, frame_out, phase
    );

    modport slave (
        input  in0, in1, in2, in3, valid0, valid1, valid2, valid3,
        output capture_en, data_out, valid_out, frame_out, phase
    );
endinterface

// File: rtl/mux4a1_serializer.sv
// mux4a1_serializer: samples four WIDTH-bit lanes every fourth clkf edge and emits them lane 0..3
//   clkf  : clock, rising edge
//   reset : synchronous, active-low
//   bus   : slave side of mux4a1_serializer_if (lanes in, serialized byte/valid/frame/phase out)
module mux4a1_serializer #(
    parameter int WIDTH = 8
) (
    input logic                 clkf,
    input logic                 reset,
    mux4a1_serializer_if.slave  bus
);
    logic [1:0]       phase;
    logic [WIDTH-1:0] hold [4];
    logic [3:0]       hvalid;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             frame_q;

    // Output stage reads the pre-edge hold registers, so at the phase-3 edge
    // lane 3 of the old word goes out while the new word is captured.
    always_ff @(posedge clkf) begin
        if (!reset) begin
            phase   <= 2'd0;
            for (int i = 0; i < 4; i++) hold[i] <= '0;
            hvalid  <= 4'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) begin
                hold[0] <= bus.in0;
                hold[1] <= bus.in1;
                hold[2] <= bus.in2;
                hold[3] <= bus.in3;
                hvalid  <= {bus.valid3, bus.valid2, bus.valid1, bus.valid0};
            end
            data_q  <= hvalid[phase] ? hold[phase] : '0;
            valid_q <= hvalid[phase];
            frame_q <= phase == 2'd0;
        end
    end

    assign bus.capture_en = phase == 2'd3;
    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.frame_out  = frame_q;
    assign bus.phase      = phase;
endmodule

// File: tb/tb_mux4a1_serializer.sv
// tb_mux4a1_serializer: table vectors, corner sequences and random stimulus against a lane-queue model
module tb_mux4a1_serializer;
    logic clkf = 1'b0;
    logic reset = 1'b0;
    always #5 clkf = ~clkf;

    mux4a1_serializer_if #(.WIDTH(8))  b8 ();
    mux4a1_serializer_if #(.WIDTH(16)) b16 ();

    mux4a1_serializer #(.WIDTH(8))  u8  (.clkf(clkf), .reset(reset), .bus(b8.slave));
    mux4a1_serializer #(.WIDTH(16)) u16 (.clkf(clkf), .reset(reset), .bus(b16.slave));

    int checks = 0;
    int failures = 0;

    // Model: a captured word becomes four queued output slots; each edge pops one.
    typedef struct packed {logic [15:0] d; logic v; logic f;} slot_t;
    slot_t q[$];
    slot_t e;
    int    mph = 0;
    logic [3:0][15:0] cur_d;
    logic [3:0]       cur_v;

    typedef struct {
        logic [3:0][15:0] d;
        logic [3:0]       v;
        logic [3:0][15:0] xd;
        logic [3:0]       xv;
    } vec_t;
    vec_t tv[4];

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0][15:0] d, input logic [3:0] v);
        cur_d = d;
        cur_v = v;
        b16.in0 = d[0]; b16.in1 = d[1]; b16.in2 = d[2]; b16.in3 = d[3];
        b8.in0 = d[0][7:0]; b8.in1 = d[1][7:0]; b8.in2 = d[2][7:0]; b8.in3 = d[3][7:0];
        b16.valid0 = v[0]; b16.valid1 = v[1]; b16.valid2 = v[2]; b16.valid3 = v[3];
        b8.valid0 = v[0]; b8.valid1 = v[1]; b8.valid2 = v[2]; b8.valid3 = v[3];
    endtask

    task automatic drive_rand();
        drive({$urandom, $urandom}, 4'($urandom));
    endtask

    task automatic model();
        if (!reset) begin
            mph = 0;
            q.delete();
            e = '0;
        end else begin
            e = q.size() != 0 ? q.pop_front() : slot_t'{d: 16'd0, v: 1'b0, f: mph == 0};
            if (mph == 3)
                for (int i = 0; i < 4; i++)
                    q.push_back(slot_t'{d: cur_v[i] ? cur_d[i] : 16'd0, v: cur_v[i], f: i == 0});
            mph = (mph + 1) % 4;
        end
    endtask

    task automatic step();
        @(posedge clkf);
        model();
        @(negedge clkf);
        cmp("model8", {19'd0, b8.data_out, b8.valid_out, b8.frame_out, b8.phase, b8.capture_en},
                      {19'd0, e.d[7:0], e.v, e.f, 2'(mph), mph == 3});
        cmp("model16", {11'd0, b16.data_out, b16.valid_out, b16.frame_out, b16.phase, b16.capture_en},
                       {11'd0, e.d, e.v, e.f, 2'(mph), mph == 3});
    endtask

    task automatic align();
        for (int i = 0; i < 8 && mph != 3; i++) step();
        cmp("align", 32'(b8.capture_en), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        int bad;
        tv[0] = '{d: {16'hD4, 16'hC3, 16'hB2, 16'hA1}, v: 4'hF,
                  xd: {16'hD4, 16'hC3, 16'hB2, 16'hA1}, xv: 4'hF};
        tv[1] = '{d: {16'h44, 16'h33, 16'h22, 16'h11}, v: 4'b0101,
                  xd: {16'h00, 16'h33, 16'h00, 16'h11}, xv: 4'b0101};
        tv[2] = '{d: {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, v: 4'hF,
                  xd: {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, xv: 4'hF};
        tv[3] = '{d: {16'h77EE, 16'h6655, 16'h5566, 16'hEE77}, v: 4'h0,
                  xd: {16'h0, 16'h0, 16'h0, 16'h0}, xv: 4'h0};

        // Reset held for three edges with random inputs.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            step();
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            step();
            cmp("phase_count", 32'(b8.phase), 32'((i + 1) % 4));
        end

        // Table vectors back to back; lanes 0..2 cycles carry junk that must be ignored.
        align();
        drive(tv[0].d, tv[0].v);
        step();
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) begin
                if (j == 3 && k < 3) drive(tv[k + 1].d, tv[k + 1].v);
                else drive_rand();
                step();
                cmp("vec16", {15'd0, b16.data_out, b16.valid_out, b16.frame_out},
                             {15'd0, tv[k].xd[j], tv[k].xv[j], j == 0});
                cmp("vec8", {23'd0, b8.data_out, b8.valid_out, b8.frame_out},
                            {23'd0, tv[k].xd[j][7:0], tv[k].xv[j], j == 0});
            end

        // Reset after lane 1 of a captured word.
        align();
        drive({16'hEF, 16'hBE, 16'hAD, 16'hDE}, 4'hF);
        step();
        drive_rand();
        step();
        cmp("rst_lane0", 32'(b8.data_out), 32'hDE);
        step();
        cmp("rst_lane1", 32'(b8.data_out), 32'hAD);
        reset = 1'b0;
        step();
        cmp("rst_zero", {20'd0, b8.data_out, b8.valid_out, b8.frame_out, b8.phase},
                        32'd0);
        reset = 1'b1;
        drive({16'h55, 16'h55, 16'h55, 16'h55}, 4'hF);
        first = -1;
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (b8.valid_out && first < 0) first = i;
            if (b8.data_out == 8'hBE || b8.data_out == 8'hEF) bad++;
        end
        cmp("first_valid_edge", 32'(first), 32'd5);
        cmp("no_stale_lanes", 32'(bad), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reset = $urandom_range(0, 60) != 0;
            drive_rand();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
